// File: rtl/map_cell_writer_if.sv
// Request channel plus the map RAM port owned by map_cell_writer.
// The master side is the requester/RAM environment; the slave side is the writer.
interface map_cell_writer_if #(
    parameter int unsigned W  = 11,
    parameter int unsigned AW = 5
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [9:0]    req_x;
    logic [8:0]    req_y;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_rdata;
    logic          ram_we;
    logic [W-1:0]  ram_wdata;
    logic          done;
    logic          err;
    logic          busy;

    modport master (
        output req_valid, req_op, req_x, req_y, ram_rdata,
        input  req_ready, ram_addr, ram_we, ram_wdata, done, err, busy
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, ram_rdata,
        output req_ready, ram_addr, ram_we, ram_wdata, done, err, busy
    );
endinterface

// File: rtl/map_cell_writer.sv
// Serialized read-modify-write of one wall bit in the row-addressable maze map,
// or a sweep that zeroes every row. Owns the map RAM write port.
`ifndef CELL_SIZE
`define CELL_SIZE 16
`endif
`ifndef MAZE_X0
`define MAZE_X0 32
`endif
`ifndef MAZE_Y0
`define MAZE_Y0 16
`endif
`ifndef MAP_WIDTH
`define MAP_WIDTH 11
`endif
`ifndef MAP_HEIGHT
`define MAP_HEIGHT 21
`endif

module map_cell_writer #(
    parameter int unsigned CELL_SIZE  = `CELL_SIZE,
    parameter int unsigned MAZE_X0    = `MAZE_X0,
    parameter int unsigned MAZE_Y0    = `MAZE_Y0,
    parameter int unsigned MAP_WIDTH  = `MAP_WIDTH,
    parameter int unsigned MAP_HEIGHT = `MAP_HEIGHT
) (
    input  logic               clk,
    input  logic               rst,
    map_cell_writer_if.slave   bus
);
    localparam int unsigned W        = MAP_WIDTH;
    localparam int unsigned AW       = $clog2(MAP_HEIGHT);
    localparam int unsigned CW       = $clog2(MAP_WIDTH);
    localparam int unsigned CS_SHIFT = $clog2(CELL_SIZE);
    localparam int unsigned X_END    = MAZE_X0 + MAP_WIDTH * CELL_SIZE;
    localparam int unsigned Y_END    = MAZE_Y0 + MAP_HEIGHT * CELL_SIZE;

    localparam logic [1:0] OP_CLR_BIT = 2'b00;
    localparam logic [1:0] OP_SET_BIT = 2'b01;
    localparam logic [1:0] OP_TOG_BIT = 2'b10;
    localparam logic [1:0] OP_CLR_ALL = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        CLR  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [1:0]    op_q, op_n;
    logic [AW-1:0] row_q, row_n;
    logic [CW-1:0] bidx_q, bidx_n;
    logic          flag_q, flag_n;
    logic [AW-1:0] clr_cnt, cnt_n;
    logic [AW-1:0] addr_q, addr_n;
    logic          we_q, we_n;
    logic          done_q, done_n;
    logic          err_q, err_n;
    logic          ready_q, ready_n;

    logic          in_region_c;
    logic [9:0]    rel_x_c;
    logic [8:0]    rel_y_c;
    logic [AW-1:0] row_c;
    logic [CW-1:0] col_c;
    logic [CW-1:0] bidx_c;
    logic          accept_c;
    logic [W-1:0]  mask_c;
    logic [W-1:0]  mod_row_c;

    // Region test and tile coordinates; offsets are only formed once inside the maze
    always_comb begin
        in_region_c = (32'(bus.req_x) >= MAZE_X0) && (32'(bus.req_x) < X_END) &&
                      (32'(bus.req_y) >= MAZE_Y0) && (32'(bus.req_y) < Y_END);
        rel_x_c     = '0;
        rel_y_c     = '0;
        if (in_region_c) begin
            rel_x_c = 10'(32'(bus.req_x) - MAZE_X0);
            rel_y_c = 9'(32'(bus.req_y) - MAZE_Y0);
        end
        col_c  = CW'(rel_x_c >> CS_SHIFT);
        row_c  = AW'(rel_y_c >> CS_SHIFT);
        bidx_c = CW'(MAP_WIDTH - 1) - col_c;
    end

    assign accept_c = bus.req_valid && ready_q;

    // Column 0 lives in the row MSB, so the latched index is already mirrored
    always_comb begin
        mask_c    = W'(1) << bidx_q;
        mod_row_c = bus.ram_rdata;
        unique case (op_q)
            OP_CLR_BIT: mod_row_c = bus.ram_rdata & ~mask_c;
            OP_SET_BIT: mod_row_c = bus.ram_rdata | mask_c;
            OP_TOG_BIT: mod_row_c = bus.ram_rdata ^ mask_c;
            default:    mod_row_c = bus.ram_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            row_q   <= '0;
            bidx_q  <= '0;
            flag_q  <= 1'b0;
            clr_cnt <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_n;
            op_q    <= op_n;
            row_q   <= row_n;
            bidx_q  <= bidx_n;
            flag_q  <= flag_n;
            clr_cnt <= cnt_n;
            addr_q  <= addr_n;
            we_q    <= we_n;
            done_q  <= done_n;
            err_q   <= err_n;
            ready_q <= ready_n;
        end
    end

    // Next state and the next values of every registered output
    always_comb begin
        state_n = state;
        op_n    = op_q;
        row_n   = row_q;
        bidx_n  = bidx_q;
        flag_n  = flag_q;
        cnt_n   = clr_cnt;
        addr_n  = addr_q;
        we_n    = 1'b0;

        unique case (state)
            IDLE, FIN: begin
                if (state == FIN) begin
                    state_n = IDLE;
                end
                if (accept_c) begin
                    op_n   = bus.req_op;
                    row_n  = row_c;
                    bidx_n = bidx_c;
                    flag_n = 1'b0;
                    if (bus.req_op == OP_CLR_ALL) begin
                        state_n = CLR;
                        cnt_n   = '0;
                        addr_n  = '0;
                        we_n    = 1'b1;
                    end else if (!in_region_c) begin
                        state_n = FIN;
                        flag_n  = 1'b1;
                    end else begin
                        state_n = RD;
                        addr_n  = row_c;
                    end
                end
            end
            RD: begin
                state_n = WR;
                addr_n  = row_q;
                we_n    = 1'b1;
            end
            WR: begin
                state_n = FIN;
            end
            CLR: begin
                // Stop on the last row so no address beyond the map is ever driven
                if (clr_cnt == AW'(MAP_HEIGHT - 1)) begin
                    state_n = FIN;
                end else begin
                    cnt_n  = AW'(clr_cnt + 1'b1);
                    addr_n = AW'(clr_cnt + 1'b1);
                    we_n   = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        done_n  = (state_n == FIN) && !flag_n;
        err_n   = (state_n == FIN) && flag_n;
        ready_n = (state_n == IDLE) || (state_n == FIN);
    end

    // Write data follows the read data within the WR cycle; zero everywhere else
    assign bus.ram_wdata = (state == WR) ? mod_row_c : '0;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_we    = we_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.req_ready = ready_q;
    assign bus.busy      = !ready_q;

endmodule
